rnd_sequencer: RTL and testbench
================================

Name: rnd_sequencer

Overview:
- Control FSM for the LFSR random-number datapath: drives `x_init`, `x_en`, `co_init` and `co_en`, and consumes the datapath's `co_co`.
- Once per start request: loads the seed, then repeatedly shifts the LFSR until the step counter carries out. At each carry-out it samples the 2-bit `x_out`.
- Packs `NUM_PAIRS` samples into one random word. The word is offered to the hash core through a valid/ack handshake.

Parameters:
- `NUM_PAIRS`, default 4: number of 2-bit samples per output word; legal range 1..16.
- `PAIR_CNT_W`, default 4: width of the internal pair counter; must satisfy 2^`PAIR_CNT_W` >= `NUM_PAIRS`.
- `TIMEOUT`, default 32: maximum SHIFT-state cycles without `co_co`; used only when `RND_WDOG_EN` is defined.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request one random word; sampled only in IDLE.
- `co_co`  in  1  — carry-out from the datapath step counter.
- `x_out`  in  2  — datapath LFSR top two bits.
- `rnd_ack`  in  1  — consumer accepts `rnd_word`.
- `x_init`  out  1  — load seed into LFSR.
- `x_en`  out  1  — LFSR shift enable.
- `co_init`  out  1  — clear step counter.
- `co_en`  out  1  — step counter enable.
- `busy`  out  1  — high in every state except IDLE.
- `rnd_valid`  out  1  — `rnd_word` holds a completed word.
- `rnd_word`  out  2*`NUM_PAIRS`  — packed samples; first sample in the MSBs.
- `err`  out  1  — watchdog error flag; constant 0 when the macro is absent.

Behaviour:
- **Reset:** `rst` high, asynchronous, forces IDLE. All outputs go to 0, including `rnd_word`; the pair counter and the watchdog counter clear. Reset mid-operation abandons the word with no partial valid.
- **Output encoding:** all control outputs are Moore, decoded from state only. No combinational path from inputs to outputs.
- **States:** IDLE, INIT, SHIFT, CAPT, DONE (plus ERR with the macro).
- **IDLE:**
  - All control outputs 0.
  - `start`=1 -> INIT; the pair counter clears.
  - `start` is ignored in every other state (no queuing).
- **INIT (exactly 1 cycle):**
  - `x_init`=1, `co_init`=1.
  - Next state is SHIFT.
- **SHIFT:**
  - `x_en`=1, `co_en`=1.
  - Stays in SHIFT while `co_co`=0.
  - `co_co`=1 -> CAPT. The shift in that same cycle still occurs.
- **CAPT (exactly 1 cycle):**
  - `x_en`=0, `co_en`=0, `co_init`=1.
  - `x_out` is written into slot `pair_cnt`. Slot k occupies `rnd_word` bits [2*`NUM_PAIRS`-1-2k -: 2].
  - `pair_cnt` increments.
  - If the incremented value equals `NUM_PAIRS` -> DONE; otherwise -> SHIFT.
  - The LFSR is NOT re-seeded between pairs.
- **DONE:**
  - `rnd_valid`=1; `rnd_word` is stable.
  - `rnd_ack`=1 -> IDLE, with `rnd_valid` falling the next cycle.
  - `rnd_word` holds its value after leaving DONE until the next CAPT overwrites it.
- **Spurious inputs:** `rnd_ack` outside DONE is ignored; `co_co` outside SHIFT is ignored.
- **Back-to-back words:** `start` held high from DONE re-enters INIT on the cycle after IDLE is reached. Minimum gap is one IDLE cycle.
- **Latency:** with the carry-out arriving after N SHIFT cycles per pair, `start` -> `rnd_valid` takes 1 + `NUM_PAIRS`*(N+1) + 1 cycles. The first +1 is the IDLE->INIT edge.
- **Walkthrough:** default `NUM_PAIRS`=4 with N=5 gives 26 cycles.

Optional Feature:
- **Macro:** `RND_WDOG_EN`.
- **Defined:**
  - A counter runs while in SHIFT and clears on entry to SHIFT.
  - If it reaches `TIMEOUT` with `co_co` still 0 -> ERR.
  - ERR: all control outputs 0, `err`=1, `busy`=1, `rnd_valid`=0.
  - Leaves ERR for IDLE only when `start`=1; `err` clears on that transition.
- **Undefined:** no counter and no ERR state; `err` is tied to 0; SHIFT waits indefinitely.

Test Plan:
1. **Reset and basic handshake:** assert `rst` mid-SHIFT -> all outputs 0 in the same cycle (asynchronous). Release, pulse `start` -> `x_init`=`co_init`=1 for exactly 1 cycle, then `x_en`=`co_en`=1.
2. **Word assembly:** `NUM_PAIRS`=4; bench raises `co_co` after 5 SHIFT cycles per pair; `x_out` = 2'b11, 2'b01, 2'b10, 2'b00 at the successive CAPT cycles -> `rnd_word`=8'hD8 and `rnd_valid` in cycle 26 after `start`.
3. **Ack handling:**
   - Hold `rnd_ack`=0 for 10 cycles in DONE -> `rnd_valid` and `rnd_word` stay stable.
   - Pulse `rnd_ack` -> IDLE; `busy`=0 next cycle.
4. **Ignored inputs:**
   - `start` pulsed during SHIFT -> no re-INIT.
   - `co_co` forced high in IDLE/DONE -> no state change.
   - `rnd_ack` in SHIFT -> ignored.
5. **Back-to-back:** `start` held continuously -> each word is separated by exactly one IDLE cycle, and `x_init` is asserted once per word only.
6. **Watchdog (`RND_WDOG_EN`, `TIMEOUT`=32):**
   - `co_co` never asserted -> `err`=1 after 32 SHIFT cycles, control outputs 0.
   - `start` -> IDLE with `err`=0.
   - Without the macro, the same stimulus leaves the FSM in SHIFT indefinitely with `err`=0.

Source files
------------

// File: rtl/rnd_sequencer_if.sv
// Handshake bundle between rnd_sequencer, the LFSR datapath and the hash core.
interface rnd_sequencer_if #(
  parameter int NUM_PAIRS = 4
);

  logic                   start;
  logic                   co_co;
  logic [1:0]             x_out;
  logic                   rnd_ack;
  logic                   x_init;
  logic                   x_en;
  logic                   co_init;
  logic                   co_en;
  logic                   busy;
  logic                   rnd_valid;
  logic [2*NUM_PAIRS-1:0] rnd_word;
  logic                   err;

  modport master (
    input  start, co_co, x_out, rnd_ack,
    output x_init, x_en, co_init, co_en, busy, rnd_valid, rnd_word, err
  );

  modport slave (
    output start, co_co, x_out, rnd_ack,
    input  x_init, x_en, co_init, co_en, busy, rnd_valid, rnd_word, err
  );

endinterface

// File: rtl/rnd_sequencer.sv
// Control FSM for the LFSR random-number datapath; packs NUM_PAIRS 2-bit samples per word.
// Optional SHIFT-state watchdog with ERR state is enabled by defining RND_WDOG_EN.
module rnd_sequencer #(
  parameter int NUM_PAIRS  = 4,
  parameter int PAIR_CNT_W = 4,
  parameter int TIMEOUT    = 32
) (
  input logic             clk,
  input logic             rst,
  rnd_sequencer_if.master bus
);

  localparam int WORD_W = 2 * NUM_PAIRS;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPT,
    DONE
`ifdef RND_WDOG_EN
    , ERR
`endif
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PAIR_CNT_W-1:0] pair_cnt;
  logic [PAIR_CNT_W:0]   pair_inc;
  logic                  last_pair;
  logic [WORD_W-1:0]     word_q;

  if (NUM_PAIRS < 1 || NUM_PAIRS > 16 || (1 << PAIR_CNT_W) < NUM_PAIRS || TIMEOUT < 1) begin : g_bad_params
    $error("rnd_sequencer: illegal NUM_PAIRS/PAIR_CNT_W/TIMEOUT combination");
  end

  // One extra bit so NUM_PAIRS == 2**PAIR_CNT_W does not wrap before the compare
  assign pair_inc  = {1'b0, pair_cnt} + (PAIR_CNT_W+1)'(1);
  assign last_pair = (pair_inc == (PAIR_CNT_W+1)'(NUM_PAIRS));

`ifdef RND_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expired;

  assign wdog_expired = (wdog_cnt == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog_cnt <= '0;
    else if (state == SHIFT)
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    else
      wdog_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = INIT;
      INIT:  state_nxt = SHIFT;
      SHIFT: begin
        if (bus.co_co)
          state_nxt = CAPT;
`ifdef RND_WDOG_EN
        else if (wdog_expired)
          state_nxt = ERR;
`endif
      end
      CAPT:  state_nxt = last_pair ? DONE : SHIFT;
      DONE:  if (bus.rnd_ack) state_nxt = IDLE;
`ifdef RND_WDOG_EN
      ERR:   if (bus.start) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode: every control output is a function of the state register only
  always_comb begin
    bus.x_init    = 1'b0;
    bus.x_en      = 1'b0;
    bus.co_init   = 1'b0;
    bus.co_en     = 1'b0;
    bus.rnd_valid = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      INIT: begin
        bus.x_init  = 1'b1;
        bus.co_init = 1'b1;
      end
      SHIFT: begin
        bus.x_en  = 1'b1;
        bus.co_en = 1'b1;
      end
      CAPT:  bus.co_init   = 1'b1;
      DONE:  bus.rnd_valid = 1'b1;
`ifdef RND_WDOG_EN
      ERR:   bus.err       = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pair_cnt <= '0;
    else if (state == IDLE && bus.start)
      pair_cnt <= '0;
    else if (state == CAPT)
      pair_cnt <= pair_inc[PAIR_CNT_W-1:0];
  end

  // Slot 0 lands in the MSBs; the word is kept after DONE until the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (state == CAPT) begin
      for (int k = 0; k < NUM_PAIRS; k++) begin
        if (pair_cnt == PAIR_CNT_W'(k))
          word_q[WORD_W-1-2*k -: 2] <= bus.x_out;
      end
    end
  end

  assign bus.rnd_word = word_q;

endmodule

// File: tb/tb_rnd_sequencer.sv
// Scoreboard bench for rnd_sequencer: directed words, handshake, ignored inputs, reset, watchdog.
module tb_rnd_sequencer;

  localparam int NP = 4;

  typedef struct packed {
    logic [31:0]      n_shift;
    logic [0:3][1:0]  xs;
  } cfg_t;

  typedef struct packed {
    logic [7:0]  word;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic co_force = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  cfg_t cfg_q[$];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rnd_sequencer_if #(.NUM_PAIRS(NP)) bus ();

  rnd_sequencer #(.NUM_PAIRS(NP), .PAIR_CNT_W(4), .TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue a one-cycle start from a negedge; returns at the negedge of the INIT cycle
  task automatic applyStimulus(input cfg_t c, input logic [7:0] w, input int lat, input bit expect_word);
    cfg_q.push_back(c);
    if (expect_word) sb_q.push_back(exp_t'{word: w, due: 32'(cyc + lat)});
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Datapath stand-in: step counter carries out on the n_shift-th SHIFT cycle
  cfg_t cur = '0;
  int   steps = 0;
  int   pair = 0;
  always @(posedge clk) begin
    #1;
    if (bus.x_init) begin
      if (cfg_q.size() > 0) cur = cfg_q.pop_front();
      pair = 0;
    end
    if (bus.co_init) steps = 0;
    else if (bus.x_en) steps++;
    bus.co_co = co_force || (bus.x_en && cur.n_shift != 0 && steps == int'(cur.n_shift));
    if (bus.co_init && !bus.x_init && pair < 4) begin
      bus.x_out = cur.xs[pair];
      pair++;
    end else begin
      bus.x_out = ~cur.xs[(pair < 4) ? pair : 0];
    end
  end

  // Monitor: pops the scoreboard on every rising rnd_valid
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.rnd_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got word %0h with nothing expected (cycle %0d)", bus.rnd_word, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("word", 32'(bus.rnd_word), 32'(e.word));
        checkOutput("latency_cycle", 32'(cyc), e.due);
      end
    end
    prev_valid = bus.rnd_valid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    cfg_t c_d8, c_3d, c_a7, c_stall;
    int   n, xi, gap;
    bit   saw_valid;

    c_d8    = cfg_t'{n_shift: 32'd5, xs: {2'b11, 2'b01, 2'b10, 2'b00}};
    c_3d    = cfg_t'{n_shift: 32'd1, xs: {2'b00, 2'b11, 2'b11, 2'b01}};
    c_a7    = cfg_t'{n_shift: 32'd3, xs: {2'b10, 2'b10, 2'b01, 2'b11}};
    c_stall = cfg_t'{n_shift: 32'd0, xs: {2'b01, 2'b01, 2'b01, 2'b01}};

    bus.start   = 1'b0;
    bus.rnd_ack = 1'b0;
    bus.co_co   = 1'b0;
    bus.x_out   = 2'b00;

    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", 32'({bus.x_init, bus.x_en, bus.co_init, bus.co_en, bus.busy, bus.rnd_valid, bus.err}), 32'h0);
    checkOutput("reset_word", 32'(bus.rnd_word), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word D8 with five shifts per pair: INIT pulse, then shifting, valid 26 cycles after start
    applyStimulus(c_d8, 8'hD8, 26, 1'b1);
    checkOutput("init_pulse", 32'({bus.x_init, bus.co_init, bus.x_en, bus.co_en}), 32'b1100);
    @(negedge clk);
    checkOutput("first_shift", 32'({bus.x_init, bus.co_init, bus.x_en, bus.co_en}), 32'b0011);
    n = 0;
    while (!bus.rnd_valid && n < 60) begin @(negedge clk); n++; end
    checkOutput("d8_reached_done", 32'(bus.rnd_valid), 32'h1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("done_hold", 32'({bus.rnd_valid, bus.busy, bus.rnd_word}), {22'h0, 2'b11, 8'hD8});
    end
    bus.rnd_ack = 1'b1;
    @(negedge clk);
    bus.rnd_ack = 1'b0;
    checkOutput("ack_to_idle", 32'({bus.rnd_valid, bus.busy}), 32'h0);
    checkOutput("word_kept", 32'(bus.rnd_word), 32'hD8);

    // Carry-out in IDLE must not wake the FSM
    co_force = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("co_in_idle", 32'(bus.busy), 32'h0);
    co_force = 1'b0;
    @(negedge clk);

    // Word A7 with start and ack pulsed during SHIFT
    applyStimulus(c_a7, 8'hA7, 18, 1'b1);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.rnd_ack = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.rnd_ack = 1'b0;
    xi = 0;
    n  = 0;
    while (!bus.rnd_valid && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.x_init) xi++;
    end
    checkOutput("no_reinit", 32'(xi), 32'h0);
    checkOutput("a7_reached_done", 32'(bus.rnd_valid), 32'h1);

    // Carry-out in DONE is ignored
    co_force = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("co_in_done", 32'({bus.rnd_valid, bus.rnd_word}), {23'h0, 1'b1, 8'hA7});
    co_force    = 1'b0;
    bus.rnd_ack = 1'b1;
    @(negedge clk);
    bus.rnd_ack = 1'b0;
    checkOutput("a7_ack_idle", 32'(bus.busy), 32'h0);

    // Back-to-back: start and ack held, D8 then 3D with one IDLE cycle between
    cfg_q.push_back(c_d8);
    cfg_q.push_back(c_3d);
    sb_q.push_back(exp_t'{word: 8'hD8, due: 32'(cyc + 26)});
    sb_q.push_back(exp_t'{word: 8'h3D, due: 32'(cyc + 37)});
    bus.start   = 1'b1;
    bus.rnd_ack = 1'b1;
    xi = 0;
    gap = 0;
    saw_valid = 1'b0;
    n = 0;
    while (!(xi == 2 && bus.rnd_valid) && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.x_init) xi++;
      if (xi == 2) bus.start = 1'b0;
      if (bus.rnd_valid) saw_valid = 1'b1;
      if (saw_valid && xi < 2 && !bus.busy) gap++;
    end
    bus.start   = 1'b0;
    checkOutput("b2b_x_init_count", 32'(xi), 32'h2);
    checkOutput("b2b_idle_gap", 32'(gap), 32'h1);
    @(negedge clk);
    bus.rnd_ack = 1'b0;
    checkOutput("b2b_end_idle", 32'(bus.busy), 32'h0);

    // Asynchronous reset in the middle of SHIFT
    applyStimulus(c_d8, 8'h00, 0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_shift", 32'(bus.x_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ctrl", 32'({bus.x_init, bus.x_en, bus.co_init, bus.co_en, bus.busy, bus.rnd_valid, bus.err}), 32'h0);
    checkOutput("async_rst_word", 32'(bus.rnd_word), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("no_partial_valid", 32'({bus.rnd_valid, bus.busy}), 32'h0);

    // Carry-out never arrives
    applyStimulus(c_stall, 8'h00, 0, 1'b0);
    repeat (32) @(negedge clk);
    checkOutput("stall_last_shift", 32'({bus.x_en, bus.err}), 32'b10);
    @(negedge clk);
`ifdef RND_WDOG_EN
    checkOutput("wdog_err", 32'({bus.x_init, bus.x_en, bus.co_init, bus.co_en, bus.rnd_valid, bus.err, bus.busy}), 32'b0000011);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("wdog_clear", 32'({bus.err, bus.busy}), 32'h0);
`else
    checkOutput("no_wdog_shift", 32'({bus.x_en, bus.err, bus.busy}), 32'b101);
    repeat (20) @(negedge clk);
    checkOutput("no_wdog_still", 32'({bus.x_en, bus.err, bus.busy}), 32'b101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("recover_idle", 32'(bus.busy), 32'h0);
`endif

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
